// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmit line between two byte requesters.
// Requesters are served round-robin through a valid/ready handshake that happens
// only while idle; the granted byte is sent as start bit, DATA_W data bits LSB
// first and one stop bit, with bit timing set by CLKS_PER_BIT.
// Optional feature macro: UART_ARB_PARITY_EN inserts an even-parity bit
// (XOR of the latched byte) between the last data bit and the stop bit.
module uart_tx_arb #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx,
  output logic              busy,
  output logic              grant_id
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_ARB_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cyc, cyc_d;
  logic [BW-1:0]     bitc, bitc_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              gid, gid_d;
  logic              ptr, ptr_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              win0, win1;
  logic              grant0, grant1;
  logic              cyc_wrap;
`ifdef UART_ARB_PARITY_EN
  logic              par, par_d;
`endif

  // Next-state, counters, arbitration and the value tx must hold after the edge.
  always_comb begin
    state_d  = state;
    cyc_d    = cyc;
    bitc_d   = bitc;
    shreg_d  = shreg;
    gid_d    = gid;
    ptr_d    = ptr;
    grant0   = 1'b0;
    grant1   = 1'b0;
    tx_d     = 1'b1;
`ifdef UART_ARB_PARITY_EN
    par_d    = par;
`endif
    win0     = req0_valid && (!req1_valid || !ptr);
    win1     = req1_valid && (!req0_valid || ptr);
    cyc_wrap = (cyc == CYC_LAST);

    case (state)
      IDLE: begin
        cyc_d  = '0;
        bitc_d = '0;
        if (win0) begin
          grant0  = 1'b1;
          shreg_d = req0_data;
          gid_d   = 1'b0;
          ptr_d   = 1'b1;
          state_d = START;
`ifdef UART_ARB_PARITY_EN
          par_d   = ^req0_data;
`endif
        end else if (win1) begin
          grant1  = 1'b1;
          shreg_d = req1_data;
          gid_d   = 1'b1;
          ptr_d   = 1'b0;
          state_d = START;
`ifdef UART_ARB_PARITY_EN
          par_d   = ^req1_data;
`endif
        end
      end
      START: begin
        if (cyc_wrap) begin
          cyc_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc + CW'(1);
        end
      end
      DATA: begin
        if (cyc_wrap) begin
          cyc_d   = '0;
          shreg_d = shreg >> 1;
          if (bitc == BIT_LAST) begin
            bitc_d  = '0;
`ifdef UART_ARB_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitc_d = bitc + BW'(1);
          end
        end else begin
          cyc_d = cyc + CW'(1);
        end
      end
`ifdef UART_ARB_PARITY_EN
      PARITY: begin
        if (cyc_wrap) begin
          cyc_d   = '0;
          state_d = STOP;
        end else begin
          cyc_d = cyc + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cyc_wrap) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_ARB_PARITY_EN
      PARITY:  tx_d = par;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any frame and favours requester 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cyc    <= '0;
      bitc   <= '0;
      shreg  <= '0;
      gid    <= 1'b0;
      ptr    <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      cyc    <= cyc_d;
      bitc   <= bitc_d;
      shreg  <= shreg_d;
      gid    <= gid_d;
      ptr    <= ptr_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

`ifdef UART_ARB_PARITY_EN
  // Parity of the byte latched at grant time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else begin
      par <= par_d;
    end
  end
`endif

  // Readys are held low while reset is asserted even though the FSM sits in IDLE.
  assign req0_ready = grant0 & rst;
  assign req1_ready = grant1 & rst;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = gid;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb with a frame-level reference model.
// Honours UART_ARB_PARITY_EN to match the design build.
module tb_uart_tx_arb;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_ARB_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          tx, busy, grant_id;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: frame bits of the frame in flight and cycles left in it.
  int            remaining = 0;
  logic          ptrExp    = 1'b0;
  logic          gidExp    = 1'b0;
  logic          frameBits [0:10];
  logic          exp0, exp1;
  logic [DW-1:0] modelByte;

  int            id, n;
  logic [10:0]   obs;
  int            busyCnt;

  always #5 clk = ~clk;

  uart_tx_arb #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic checkOutput(input string name, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [DW-1:0] d0,
                               input logic v1, input logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
  endtask

  // Lets the handshake edge pass, then updates the valids.
  task automatic afterGrant(input logic v0, input logic v1);
    @(posedge clk);
    #1;
    req0_valid = v0;
    req1_valid = v1;
  endtask

  task automatic waitGrant(output int gotId, output int cycles);
    gotId  = -1;
    cycles = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gotId  = req1_ready ? 1 : 0;
        cycles = i;
        break;
      end
    end
    if (gotId < 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL grant_timeout: no ready within 200 cycles at %0t", $time);
    end
  endtask

  task automatic captureFrame(output logic [10:0] bits, output int busyCycles);
    bits       = '0;
    busyCycles = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (k % CPB == 1) bits[k / CPB] = tx;
    end
  endtask

  // Compare process: every falling edge the outputs are checked against the model.
  always @(negedge clk) begin
    if (!rst) begin
      remaining = 0;
      ptrExp    = 1'b0;
      gidExp    = 1'b0;
      checkOutput("rst_tx", tx, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_ready0", req0_ready, 1'b0);
      checkOutput("rst_ready1", req1_ready, 1'b0);
      checkOutput("rst_gid", grant_id, 1'b0);
    end else if (remaining == 0) begin
      exp0 = req0_valid && (!req1_valid || ptrExp == 1'b0);
      exp1 = req1_valid && (!req0_valid || ptrExp == 1'b1);
      checkOutput("idle_tx", tx, 1'b1);
      checkOutput("idle_busy", busy, 1'b0);
      checkOutput("idle_ready0", req0_ready, exp0);
      checkOutput("idle_ready1", req1_ready, exp1);
      checkOutput("idle_gid", grant_id, gidExp);
      if (exp0 || exp1) begin
        modelByte = exp0 ? req0_data : req1_data;
        frameBits[0] = 1'b0;
        for (int i = 0; i < DW; i++) frameBits[1 + i] = modelByte[i];
`ifdef UART_ARB_PARITY_EN
        frameBits[DW + 1] = ^modelByte;
`endif
        frameBits[NBITS - 1] = 1'b1;
        gidExp    = exp1;
        ptrExp    = exp0;
        remaining = FRAME;
      end
    end else begin
      checkOutput("frame_tx", tx, frameBits[(FRAME - remaining) / CPB]);
      checkOutput("frame_busy", busy, 1'b1);
      checkOutput("frame_ready0", req0_ready, 1'b0);
      checkOutput("frame_ready1", req1_ready, 1'b0);
      checkOutput("frame_gid", grant_id, gidExp);
      remaining--;
    end
  end

  initial begin
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;

    // Reset, then 50 idle cycles with no requests.
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("reset_idle_tx", tx, 1'b1);
    checkOutput("reset_idle_busy", busy, 1'b0);

    // Single frame from requester 0.
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    waitGrant(id, n);
    checkCount("single_grant_id", id, 0);
    checkCount("single_grant_latency", n, 1);
    afterGrant(1'b0, 1'b0);
    captureFrame(obs, busyCnt);
`ifdef UART_ARB_PARITY_EN
    checkCount("single_bits", int'(obs), int'(11'b10101001010));
    checkCount("single_busy_cycles", busyCnt, 44);
`else
    checkCount("single_bits", int'(obs[9:0]), int'(10'b1101001010));
    checkCount("single_busy_cycles", busyCnt, 40);
`endif
    checkOutput("single_gid", grant_id, 1'b0);
    @(negedge clk);
    checkOutput("single_end_busy", busy, 1'b0);

    // Simultaneous requests present from reset.
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req0_valid = 1'b1;
    req0_data  = 8'h11;
    req1_valid = 1'b1;
    req1_data  = 8'h22;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    waitGrant(id, n);
    checkCount("sim_first_id", id, 0);
    checkCount("sim_first_latency", n, 1);
    afterGrant(1'b0, 1'b1);
    waitGrant(id, n);
    checkCount("sim_second_id", id, 1);
    checkCount("sim_gap", n, FRAME + 1);
    checkOutput("sim_gid_before", grant_id, 1'b0);
    afterGrant(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sim_gid_after", grant_id, 1'b1);

    // Fairness: both held for four frames, then single-requester cases.
    applyStimulus(1'b1, 8'h5A, 1'b1, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      waitGrant(id, n);
      checkCount("fair_order", id, i % 2);
    end
    afterGrant(1'b0, 1'b1);
    waitGrant(id, n);
    checkCount("fair_alone1", id, 1);
    afterGrant(1'b1, 1'b1);
    waitGrant(id, n);
    checkCount("fair_after1", id, 0);
    afterGrant(1'b0, 1'b0);
    repeat (FRAME + 2) @(negedge clk);

    // Mid-frame reset during data bit 3 of 0x3C, with requester 1 waiting.
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h55);
    waitGrant(id, n);
    checkCount("mid_first_id", id, 0);
    afterGrant(1'b0, 1'b1);
    repeat (18) @(negedge clk);
    checkOutput("mid_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_tx", tx, 1'b1);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_ready1", req1_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    waitGrant(id, n);
    checkCount("mid_regrant_id", id, 1);
    checkCount("mid_regrant_latency", n, 1);
    afterGrant(1'b0, 1'b0);
    captureFrame(obs, busyCnt);
`ifdef UART_ARB_PARITY_EN
    checkCount("mid_bits", int'(obs), int'(11'b10010101010));
`else
    checkCount("mid_bits", int'(obs[9:0]), int'(10'b1010101010));
`endif
    checkOutput("mid_gid", grant_id, 1'b1);
    @(negedge clk);

`ifdef UART_ARB_PARITY_EN
    // Parity bit for bytes of odd and even weight.
    applyStimulus(1'b1, 8'h07, 1'b0, 8'h00);
    waitGrant(id, n);
    afterGrant(1'b0, 1'b0);
    captureFrame(obs, busyCnt);
    checkOutput("parity_07", obs[9], 1'b1);
    checkCount("parity_len", busyCnt, 44);
    @(negedge clk);
    applyStimulus(1'b1, 8'h03, 1'b0, 8'h00);
    waitGrant(id, n);
    afterGrant(1'b0, 1'b0);
    captureFrame(obs, busyCnt);
    checkOutput("parity_03", obs[9], 1'b0);
    @(negedge clk);
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
